// File: rtl/grace_pkg.sv
// Shared definitions for Grace bus masters: sequencer state encoding and default widths.
// Imported by the arbiter top and available to other Grace masters.
package grace_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        REL  = 2'd2
    } grace_state_e;

    localparam int GRACE_DW    = 32;
    localparam int GRACE_AW    = 8;
    localparam int GRACE_TO    = 15;
    // Access counter width; large enough for the maximum timeout of 255.
    localparam int GRACE_CNT_W = 8;

endpackage

// File: rtl/grace_rr_pick.sv
// Combinational round-robin picker: first set request at or above the pointer,
// wrapping past NR-1, returned as a one-hot grant with a valid flag.
module grace_rr_pick #(
    parameter int NR = 4,
    parameter int PW = $clog2(NR)
) (
    input  logic [NR-1:0] req_i,
    input  logic [PW-1:0] ptr_i,
    output logic [NR-1:0] gnt_o,
    output logic          vld_o
);

    logic [PW-1:0] idx;

    always_comb begin
        gnt_o = '0;
        vld_o = 1'b0;
        idx   = '0;
        for (int i = 0; i < NR; i++) begin
            idx = PW'((int'(ptr_i) + i) % NR);
            if (!vld_o && req_i[idx]) begin
                gnt_o[idx] = 1'b1;
                vld_o      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/grace_arb.sv
// Round-robin arbiter and access sequencer sharing one Grace bus among NR requesters.
// One registered CS pulse per access, acknowledge timeout, and a release phase between accesses.
module grace_arb
    import grace_pkg::*;
#(
    parameter int NR = 4,
    parameter int DW = GRACE_DW,
    parameter int AW = GRACE_AW,
    parameter int TO = GRACE_TO
) (
    input  logic             Grace_Ck,
    input  logic             Grace_Rs,
    input  logic [NR-1:0]    Req_Vld,
    input  logic [NR-1:0]    Req_WR,
    input  logic [NR*AW-1:0] Req_Addr,
    input  logic [NR*DW-1:0] Req_WD,
    output logic [NR-1:0]    Req_Done,
    output logic             Req_Err,
    output logic [DW-1:0]    Req_RD,
    input  logic             Grace_Re,
    output logic             Grace_CS,
    output logic             Grace_WR,
    output logic [AW-1:0]    Grace_Addr,
    output logic [DW-1:0]    Grace_WD,
    input  logic             Grace_Ac,
    input  logic [DW-1:0]    Grace_RD,
    output grace_state_e     Dbg_State
);

    localparam int PW = $clog2(NR);
    localparam int CW = GRACE_CNT_W;

    grace_state_e     state_q;
    logic [PW-1:0]    ptr_q;
    logic [PW-1:0]    sel_q;
    logic [CW-1:0]    cnt_q;
    logic             cs_q;
    logic             wr_q;
    logic [AW-1:0]    addr_q;
    logic [DW-1:0]    wd_q;
    logic [NR-1:0]    done_q;
    logic             err_q;
    logic [DW-1:0]    rd_q;

    logic [NR-1:0]    pick_gnt;
    logic             pick_vld;
    logic [PW-1:0]    pick_idx;

    grace_rr_pick #(
        .NR (NR),
        .PW (PW)
    ) u_pick (
        .req_i (Req_Vld),
        .ptr_i (ptr_q),
        .gnt_o (pick_gnt),
        .vld_o (pick_vld)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NR; i++) begin
            if (pick_gnt[i]) begin
                pick_idx = PW'(i);
            end
        end
    end

    always_ff @(posedge Grace_Ck or negedge Grace_Rs) begin
        if (!Grace_Rs) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            cnt_q   <= '0;
            cs_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wd_q    <= '0;
            done_q  <= '0;
            err_q   <= 1'b0;
            rd_q    <= '0;
        end else begin
            done_q <= '0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (Grace_Re && pick_vld) begin
                        sel_q   <= pick_idx;
                        wr_q    <= Req_WR[pick_idx];
                        addr_q  <= Req_Addr[pick_idx*AW +: AW];
                        wd_q    <= Req_WD[pick_idx*DW +: DW];
                        cs_q    <= 1'b1;
                        cnt_q   <= '0;
                        ptr_q   <= (int'(pick_idx) == NR - 1) ? '0 : pick_idx + 1'b1;
                        state_q <= ACC;
                    end
                end
                ACC: begin
                    cnt_q <= cnt_q + 1'b1;
                    // Acknowledge takes priority over a timeout in the same cycle.
                    if (Grace_Ac) begin
                        if (!wr_q) begin
                            rd_q <= Grace_RD;
                        end
                        done_q[sel_q] <= 1'b1;
                        cs_q          <= 1'b0;
                        state_q       <= REL;
                    end else if (cnt_q == CW'(TO)) begin
                        done_q[sel_q] <= 1'b1;
                        err_q         <= 1'b1;
                        cs_q          <= 1'b0;
                        state_q       <= REL;
                    end
                end
                REL: begin
                    // Hold CS low until the slave drops Ac so a stale acknowledge
                    // cannot complete the next access.
                    if (!Grace_Ac) begin
                        cnt_q   <= '0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    cs_q    <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign Grace_CS   = cs_q;
    assign Grace_WR   = wr_q;
    assign Grace_Addr = addr_q;
    assign Grace_WD   = wd_q;
    assign Req_Done   = done_q;
    assign Req_Err    = err_q;
    assign Req_RD     = rd_q;
    assign Dbg_State  = state_q;

endmodule

// File: doc/grace_arb.md
# grace_arb

Round-robin arbiter and access sequencer that shares one Grace bus among NR local requesters. It sits between requesting engines and the Grace slave-side register blocks, such as the read-clear event registers. It drives chip-select, write and address onto the bus and waits for the slave acknowledge, with a timeout. Each chip-select rising edge is a read-clear event at the slave, so the block guarantees one clean CS pulse per access.

## Interface
- NR, 4: number of requesters, 2..8
- DW, 32: Grace data width
- AW, 8: Grace address width
- TO, 15: max cycles in ACC waiting for Grace_Ac, 1..255
- Grace_Ck  in  1  clock; all logic on rising edge
- Grace_Rs  in  1  reset, asynchronous, active-low
- Req_Vld  in  NR  per-requester access request, held until its Req_Done
- Req_WR  in  NR  1 = write, 0 = read
- Req_Addr  in  NR*AW  requester i at bits [i*AW +: AW]
- Req_WD  in  NR*DW  write data, requester i at [i*DW +: DW]
- Req_Done  out  NR  one-cycle completion pulse to the granted requester
- Req_Err  out  1  qualifies Req_Done: access ended by timeout
- Req_RD  out  DW  read data captured on acknowledge, valid with Req_Done
- Grace_Re  in  1  bus ready; 0 = do not start new accesses
- Grace_CS  out  1  chip select, registered
- Grace_WR  out  1  write strobe, registered, valid while CS=1
- Grace_Addr  out  AW  registered, valid while CS=1
- Grace_WD  out  DW  registered, valid while CS=1
- Grace_Ac  in  1  slave acknowledge, level; follows CS with 1–2 cycles latency
- Grace_RD  in  DW  slave read data, valid while Ac=1

## Operation
- Reset values (Grace_Rs=0, immediate):
  - Grace_CS, Grace_WR, Grace_Addr, Grace_WD = 0.
  - Req_Done = 0, Req_Err = 0, Req_RD = 0.
  - State IDLE, rr pointer 0, timeout counter 0.
- FSM states are IDLE, ACC and REL.
- IDLE:
  - If Grace_Re=1 and any Req_Vld=1, pick the winner g as the first set bit searching from the pointer upward, with wrap.
  - Latch g, Req_WR[g], Req_Addr[g] and Req_WD[g] into the bus registers.
  - Set CS=1, set pointer to (g+1) mod NR, go to ACC.
  - If Grace_Re=0, stay in IDLE and ignore Vld.
- ACC:
  - CS=1 and the bus fields stay frozen.
  - Counter increments every cycle.
  - On Grace_Ac=1 sampled:
    - Req_RD <= Grace_RD if read; unchanged on write.
    - Req_Done[g]=1 for one cycle, Err=0.
    - CS=0, go to REL.
  - Else if counter reaches TO:
    - Req_Done[g]=1 with Err=1; Req_RD unchanged.
    - CS=0, go to REL.
- REL:
  - CS=0; wait until Grace_Ac=0 is sampled.
  - Counter cleared, go to IDLE.
  - Minimum one cycle in REL, so CS is low for at least 2 cycles between accesses. This prevents a stale Ac from completing the next access and gives every access a distinct CS rising edge for read-clear.
- Requester rules:
  - A Vld drop during ACC is ignored; the access completes and Done still pulses.
  - A requester re-asserting Vld after Done competes normally under round-robin.
- Grace_Re falling during ACC or REL does not abort the current access.
- A late Ac after a timeout is absorbed in REL and produces no Done.

## Timing
- Req_Vld sampled high in IDLE at edge 0: CS=1 visible after edge 0.
- Slave with 1-cycle Ac (Ac high after edge 1, sampled edge 2): Done after edge 2. Request-to-Done is 3 cycles with CS high for 2 cycles.
- Slave with 2-cycle Ac: 4 cycles, CS high 3 cycles.
- Timeout: Done/Err pulse TO+1 cycles after CS rises.
- Simultaneous Ac and counter==TO in the same cycle: Ac wins (Err=0).
- Req_Done and Req_Err are registered; Req_RD holds its value until the next successful read.
- Throughput, single requester, 1-cycle slave: one access per 5 cycles.

## Structure
- Shared package grace_pkg holds:
  - the FSM state enum (IDLE/ACC/REL);
  - default widths (DW=32, AW=8);
  - the default timeout constant GRACE_TO=15.
- One sub-module, grace_rr_pick, is combinational: NR-bit request vector plus pointer gives a one-hot grant and a valid flag. It is reusable by other Grace masters.
- Top holds the FSM, counter, bus registers and response registers.

## Test plan
- Single read, 1-cycle Ac slave:
  - Stimulus: Req_Vld[0]=1, Addr=0x10, Grace_RD=0xA5A50001.
  - Response: CS high 2 cycles with Addr=0x10 and WR=0. Req_Done[0] pulses at cycle 3 with Req_RD=0xA5A50001 and Err=0.
- All four Vld held high, 1-cycle slave:
  - Response: grant order 0,1,2,3,0,1. Each access is separated by at least 2 CS-low cycles, and each Done goes only to the granted index.
- Timeout, TO=15, Ac stuck 0, Req_Vld[2] write of 0xDEADBEEF:
  - Response: CS high for exactly 16 cycles, then Done[2]=1 with Err=1. Req_RD is unchanged.
- Sticky Ac after access, with Req_Vld[1] pending:
  - Stimulus: slave holds Ac high 3 cycles after CS falls.
  - Response: next CS does not rise until 1 cycle after Ac is sampled low, and no spurious Done occurs.
- Reset and Grace_Re gating:
  - Stimulus: Grace_Rs pulled low mid-ACC.
  - Response: CS, Done and Err go to 0 immediately.
  - Stimulus: after release, Grace_Re=0 with Vld[3]=1.
  - Response: no CS.
  - Stimulus: Grace_Re=1.
  - Response: requester 3 is granted with pointer reset to 0.
